// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle control FSM for the RV64 datapath
//
// Decodes the IR opcode/funct fields and sequences every datapath strobe and
// mux select: fetch, decode, execute, memory access, write-back, branches.
// Memory accesses last MEM_WAIT+1 cycles; retired instructions are counted
// on every PC_Write cycle.
//
// Optional feature macro: UC_ILLEGAL_TRAP_EN
//   defined   -> unknown opcodes enter TRAP (illegal=1, halted=1, sticky)
//   undefined -> unknown opcodes retire as a NOP through PC_INC, illegal=0
//
// Ports:
//   clock, reset (async, active-low)
//   Op, Funct3, Funct7_5       instruction fields from the IR
//   igual                      ALU equality flag (same-cycle)
//   PC_Write                   PC load from ALU result
//   Seletor_Ula                000 idle, 001 add, 010 sub
//   mux_A_seletor              0 PC, 1 Reg A, 2 ULAOut
//   mux_B_seletor              0 Reg B, 1 const 4, 2 imm, 3 imm<<1, 4 zero
//   register_Inst_wr           IR load
//   Data_Memory_wr             data memory write
//   bancoRegisters_wr          register file write
//   Mux_Banco_Reg_Seletor      0 ULAOut, 1 memory data register
//   reset_A                    clears Reg A
//   halted, illegal            sticky status flags
//   instr_count                retired-instruction counter
//   state_dbg                  current state encoding
module uc_multiciclo #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  Op,
    input  logic [2:0]  Funct3,
    input  logic        Funct7_5,
    input  logic        igual,
    output logic        PC_Write,
    output logic [2:0]  Seletor_Ula,
    output logic [2:0]  mux_A_seletor,
    output logic [2:0]  mux_B_seletor,
    output logic        register_Inst_wr,
    output logic        Data_Memory_wr,
    output logic        bancoRegisters_wr,
    output logic [2:0]  Mux_Banco_Reg_Seletor,
    output logic        reset_A,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [3:0]  state_dbg
);
    typedef enum logic [3:0] {
        INIT        = 4'd0,
        FETCH       = 4'd1,
        DECODE      = 4'd2,
        EXEC_R      = 4'd3,
        EXEC_I      = 4'd4,
        ADDR        = 4'd5,
        MEM_RD      = 4'd6,
        WB_MEM      = 4'd7,
        MEM_WR      = 4'd8,
        WB_ALU      = 4'd9,
        BRANCH_CMP  = 4'd10,
        BRANCH_TAKE = 4'd11,
        PC_INC      = 4'd12,
        HALT        = 4'd13
`ifdef UC_ILLEGAL_TRAP_EN
        ,TRAP       = 4'd14
`endif
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q;
    logic        last, wait_st, taken;

    assign last        = cnt_q == LAST_CNT;
    assign wait_st     = state_q inside {FETCH, MEM_RD, MEM_WR};
    assign taken       = (Funct3 == 3'b000 && igual) || (Funct3 == 3'b001 && !igual);
    // The wait counter only runs inside memory-access states and returns to 0
    // on the cycle the state changes, so it never passes MEM_WAIT.
    assign cnt_d       = (wait_st && !last) ? cnt_q + 4'd1 : 4'd0;
    assign instr_count = instr_q;
    assign state_dbg   = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= 4'd0;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_q + 32'(PC_Write);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:        state_d = FETCH;
            FETCH:       state_d = last ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    7'b0110011: state_d = EXEC_R;
                    7'b0010011: state_d = EXEC_I;
                    7'b0000011,
                    7'b0100011: state_d = ADDR;
                    7'b1100011: state_d = BRANCH_CMP;
                    7'b1110011: state_d = HALT;
`ifdef UC_ILLEGAL_TRAP_EN
                    default:    state_d = TRAP;
`else
                    default:    state_d = PC_INC;
`endif
                endcase
            end
            EXEC_R,
            EXEC_I:      state_d = WB_ALU;
            ADDR:        state_d = (Op == 7'b0000011) ? MEM_RD : MEM_WR;
            MEM_RD:      state_d = last ? WB_MEM : MEM_RD;
            MEM_WR:      state_d = last ? FETCH : MEM_WR;
            WB_MEM,
            WB_ALU,
            BRANCH_TAKE,
            PC_INC:      state_d = FETCH;
            // igual is only valid this cycle, so the branch decision is Mealy.
            BRANCH_CMP:  state_d = taken ? BRANCH_TAKE : PC_INC;
            HALT:        state_d = HALT;
`ifdef UC_ILLEGAL_TRAP_EN
            TRAP:        state_d = TRAP;
`endif
            default:     state_d = INIT;
        endcase
    end

    always_comb begin
        PC_Write              = 1'b0;
        Seletor_Ula           = 3'b000;
        mux_A_seletor         = 3'b000;
        mux_B_seletor         = 3'b000;
        register_Inst_wr      = 1'b0;
        Data_Memory_wr        = 1'b0;
        bancoRegisters_wr     = 1'b0;
        Mux_Banco_Reg_Seletor = 3'b000;
        reset_A               = 1'b0;
        halted                = 1'b0;
        illegal               = 1'b0;
        case (state_q)
            // State sits in INIT throughout reset; only pulse reset_A once released.
            INIT:        reset_A = reset;
            FETCH:       register_Inst_wr = last;
            DECODE: begin
                mux_B_seletor = 3'd3;
                Seletor_Ula   = ALU_ADD;
            end
            EXEC_R: begin
                mux_A_seletor = 3'd1;
                Seletor_Ula   = Funct7_5 ? ALU_SUB : ALU_ADD;
            end
            EXEC_I,
            ADDR: begin
                mux_A_seletor = 3'd1;
                mux_B_seletor = 3'd2;
                Seletor_Ula   = ALU_ADD;
            end
            MEM_WR: begin
                Data_Memory_wr = 1'b1;
                mux_B_seletor  = last ? 3'd1 : 3'd0;
                Seletor_Ula    = last ? ALU_ADD : 3'b000;
                PC_Write       = last;
            end
            WB_MEM: begin
                Mux_Banco_Reg_Seletor = 3'd1;
                bancoRegisters_wr     = 1'b1;
                mux_B_seletor         = 3'd1;
                Seletor_Ula           = ALU_ADD;
                PC_Write              = 1'b1;
            end
            WB_ALU: begin
                bancoRegisters_wr = 1'b1;
                mux_B_seletor     = 3'd1;
                Seletor_Ula       = ALU_ADD;
                PC_Write          = 1'b1;
            end
            BRANCH_CMP: begin
                mux_A_seletor = 3'd1;
                Seletor_Ula   = ALU_SUB;
            end
            BRANCH_TAKE: begin
                mux_A_seletor = 3'd2;
                mux_B_seletor = 3'd4;
                Seletor_Ula   = ALU_ADD;
                PC_Write      = 1'b1;
            end
            PC_INC: begin
                mux_B_seletor = 3'd1;
                Seletor_Ula   = ALU_ADD;
                PC_Write      = 1'b1;
            end
            HALT:        halted = 1'b1;
`ifdef UC_ILLEGAL_TRAP_EN
            TRAP: begin
                halted  = 1'b1;
                illegal = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: scoreboard bench for uc_multiciclo at MEM_WAIT=0 and MEM_WAIT=2
module tb_uc_multiciclo;
    typedef struct packed {
        logic        pcw;
        logic [2:0]  sel;
        logic [2:0]  ma;
        logic [2:0]  mb;
        logic        irw;
        logic        dmw;
        logic        rfw;
        logic [2:0]  mbr;
        logic        ra;
        logic        hlt;
        logic        ill;
        logic [31:0] cnt;
        logic        init;
    } exp_t;

    localparam logic [2:0] ADD = 3'd1;
    localparam logic [2:0] SUB = 3'd2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int ndone = 0;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int MW = 2 * g;
        logic        reset;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f75, ig;
        logic        pcw, irw, dmw, rfw, ra, hlt, ill;
        logic [2:0]  sel, ma, mb, mbr;
        logic [31:0] icnt;
        logic [3:0]  sdbg;
        exp_t        act;
        exp_t        q[$];
        exp_t        seq[$];
        int          cnt;

        uc_multiciclo #(.MEM_WAIT(MW)) dut (
            .clock(clock), .reset(reset), .Op(op), .Funct3(f3), .Funct7_5(f75), .igual(ig),
            .PC_Write(pcw), .Seletor_Ula(sel), .mux_A_seletor(ma), .mux_B_seletor(mb),
            .register_Inst_wr(irw), .Data_Memory_wr(dmw), .bancoRegisters_wr(rfw),
            .Mux_Banco_Reg_Seletor(mbr), .reset_A(ra), .halted(hlt), .illegal(ill),
            .instr_count(icnt), .state_dbg(sdbg)
        );

        assign act = {pcw, sel, ma, mb, irw, dmw, rfw, mbr, ra, hlt, ill, icnt, sdbg == 4'd0};

        always @(negedge clock) begin
            exp_t e;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL cycle_outputs dut_mw%0d t=%0t got=%h want=%h", MW, $time, act, e);
                end
            end
        end

        function automatic exp_t base();
            exp_t e;
            e = '0;
            e.cnt = cnt;
            return e;
        endfunction

        function automatic exp_t pc4(input exp_t e0);
            exp_t e;
            e = e0;
            e.mb = 3'd1;
            e.sel = ADD;
            e.pcw = 1'b1;
            return e;
        endfunction

        task automatic add(input exp_t e);
            seq.push_back(e);
            if (e.pcw) cnt++;
        endtask

        task automatic build(input logic [6:0] o, input logic [2:0] f, input logic s, input logic i, output bit stuck);
            exp_t e;
            bit tk;
            seq.delete();
            stuck = 0;
            for (int k = 0; k <= MW; k++) begin
                e = base();
                e.irw = (k == MW);
                add(e);
            end
            e = base(); e.mb = 3'd3; e.sel = ADD; add(e);
            case (o)
                7'b0110011: begin
                    e = base(); e.ma = 3'd1; e.sel = s ? SUB : ADD; add(e);
                    e = pc4(base()); e.rfw = 1'b1; add(e);
                end
                7'b0010011: begin
                    e = base(); e.ma = 3'd1; e.mb = 3'd2; e.sel = ADD; add(e);
                    e = pc4(base()); e.rfw = 1'b1; add(e);
                end
                7'b0000011: begin
                    e = base(); e.ma = 3'd1; e.mb = 3'd2; e.sel = ADD; add(e);
                    for (int k = 0; k <= MW; k++) add(base());
                    e = pc4(base()); e.rfw = 1'b1; e.mbr = 3'd1; add(e);
                end
                7'b0100011: begin
                    e = base(); e.ma = 3'd1; e.mb = 3'd2; e.sel = ADD; add(e);
                    for (int k = 0; k <= MW; k++) begin
                        e = base();
                        if (k == MW) e = pc4(e);
                        e.dmw = 1'b1;
                        add(e);
                    end
                end
                7'b1100011: begin
                    e = base(); e.ma = 3'd1; e.sel = SUB; add(e);
                    tk = (f == 3'd0) ? i : (f == 3'd1) ? !i : 1'b0;
                    if (tk) begin
                        e = base(); e.ma = 3'd2; e.mb = 3'd4; e.sel = ADD; e.pcw = 1'b1; add(e);
                    end else add(pc4(base()));
                end
                7'b1110011: begin
                    for (int k = 0; k < 20; k++) begin e = base(); e.hlt = 1'b1; add(e); end
                    stuck = 1;
                end
                default: begin
`ifdef UC_ILLEGAL_TRAP_EN
                    for (int k = 0; k < 20; k++) begin e = base(); e.hlt = 1'b1; e.ill = 1'b1; add(e); end
                    stuck = 1;
`else
                    add(pc4(base()));
`endif
                end
            endcase
        endtask

        task automatic do_reset(input int m);
            exp_t e;
            reset = 1'b0;
            cnt = 0;
            e = '0;
            e.init = 1'b1;
            for (int k = 0; k < m; k++) q.push_back(e);
            repeat (m) @(posedge clock);
            #1;
            reset = 1'b1;
            e.ra = 1'b1;
            q.push_back(e);
            @(posedge clock);
            #1;
        endtask

        task automatic run(input logic [6:0] o, input logic [2:0] f, input logic s, input logic i, input bit may_abort);
            bit stuck, abort;
            int n;
            op = o; f3 = f; f75 = s; ig = i;
            build(o, f, s, i, stuck);
            n = seq.size();
            abort = may_abort && !stuck && ($urandom_range(9) == 0);
            if (abort) n = int'($urandom_range(n - 1, 1));
            for (int k = 0; k < n; k++) q.push_back(seq[k]);
            repeat (n) @(posedge clock);
            #1;
            if (stuck || abort) do_reset(1 + int'($urandom_range(1)));
        endtask

        initial begin
            logic [6:0] ops [6];
            logic [6:0] o;
            reset = 1'b0; op = 7'd0; f3 = 3'd0; f75 = 1'b0; ig = 1'b0; cnt = 0;
            ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011};
            @(posedge clock);
            #1;
            do_reset(3);
            run(7'b0110011, 3'd0, 1'b1, 1'b0, 0);
            run(7'b0010011, 3'd0, 1'b0, 1'b0, 0);
            run(7'b0000011, 3'd2, 1'b0, 1'b0, 0);
            run(7'b1100011, 3'd0, 1'b0, 1'b1, 0);
            run(7'b1100011, 3'd0, 1'b0, 1'b0, 0);
            run(7'b1100011, 3'd1, 1'b0, 1'b1, 0);
            run(7'b1100011, 3'd1, 1'b0, 1'b0, 0);
            run(7'b0100011, 3'd3, 1'b0, 1'b0, 0);
            run(7'b1111111, 3'd0, 1'b0, 1'b0, 0);
            run(7'b0110011, 3'd0, 1'b0, 1'b0, 0);
            run(7'b1110011, 3'd0, 1'b0, 1'b0, 0);
            for (int k = 0; k < 60; k++) begin
                o = ($urandom_range(6) == 6) ? 7'($urandom) : ops[$urandom_range(5)];
                run(o, 3'($urandom), 1'($urandom), 1'($urandom), 1);
            end
            repeat (2) @(posedge clock);
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL queue_drain dut_mw%0d got=%0d want=0", MW, q.size());
            end
            ndone++;
        end
    end

    initial begin
        int c;
        c = 0;
        while (ndone < 2 && c < 60000) begin
            @(posedge clock);
            c++;
        end
        total++;
        if (ndone < 2) begin
            bad++;
            $display("FAIL timeout got=%0d drivers done want=2", ndone);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
Multicycle control FSM sequencing the RV64 datapath: PC register, instruction memory, instruction register, register file, A/B registers, ALU operand muxes, ULAOut register, data memory and the write-back mux. It decodes the IR opcode and funct fields and drives every datapath strobe and mux select. It supports parameterised memory wait states and counts retired instructions. Instantiated in the CPU top in place of the single-opcode control unit.

Parameters:
MEM_WAIT, 0, extra wait cycles per instruction-memory and data-memory access (0..15); each access lasts MEM_WAIT+1 cycles.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
Op  in  7  IR[6:0]
Funct3  in  3  IR[14:12]
Funct7_5  in  1  IR[30]
igual  in  1  ALU equality flag (combinational, same cycle)
PC_Write  out  1  PC load from ALU result S
Seletor_Ula  out  3  000 idle, 001 add, 010 sub
mux_A_seletor  out  3  0 PC, 1 Reg A, 2 ULAOut
mux_B_seletor  out  3  0 Reg B, 1 const 4, 2 sign-ext imm, 3 imm<<1, 4 zero
register_Inst_wr  out  1  IR load
Data_Memory_wr  out  1  data memory write
bancoRegisters_wr  out  1  register file write
Mux_Banco_Reg_Seletor  out  3  0 ULAOut, 1 memory data register
reset_A  out  1  clears Reg A
halted  out  1  sticky halt flag
illegal  out  1  illegal-opcode flag (macro-dependent)
instr_count  out  32  retired-instruction counter
state_dbg  out  4  current state encoding

Behaviour:
- Reset asserted (reset=0): state=INIT, wait counter=0, instr_count=0, halted=0, illegal=0. All strobes 0 and all selects 000 while in reset.
- Default in every state: all strobes 0, selects 000, except where listed below.
- INIT (1 cycle): reset_A=1 -> FETCH.
- FETCH (MEM_WAIT+1 cycles, counter counts up): register_Inst_wr=1 in the last cycle only -> DECODE.
- DECODE: A=0, B=3, add. ULAOut latches the branch target PC+(imm<<1). Next state by Op:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> ADDR
  - 1100011 -> BRANCH_CMP
  - 1110011 -> HALT
  - any other opcode -> ILLEGAL path
- EXEC_R: A=1, B=0; Seletor = sub if Funct7_5 else add -> WB_ALU.
- EXEC_I: A=1, B=2, add -> WB_ALU.
- ADDR: A=1, B=2, add -> MEM_RD if Op=0000011, else MEM_WR.
- MEM_RD: MEM_WAIT+1 cycles, no strobes -> WB_MEM.
- WB_MEM: Mux_Banco=1, bancoRegisters_wr=1; PC+4 via A=0, B=1, add, PC_Write=1 -> FETCH.
- MEM_WR: Data_Memory_wr=1 for all MEM_WAIT+1 cycles. In the last cycle also PC+4 with PC_Write=1 -> FETCH.
- WB_ALU: Mux_Banco=0, bancoRegisters_wr=1, PC+4 with PC_Write=1 -> FETCH.
- BRANCH_CMP: A=1, B=0, sub.
  - taken = (Funct3=000 & igual) | (Funct3=001 & !igual).
  - taken -> BRANCH_TAKE, else PC_INC.
  - Any other Funct3 is treated as not taken.
- BRANCH_TAKE: A=2, B=4, add, PC_Write=1 -> FETCH.
- PC_INC: A=0, B=1, add, PC_Write=1 -> FETCH.
- HALT: halted=1, all strobes 0. Stays in HALT until reset.
- instr_count increments by 1 (wrapping at 2^32) on every cycle with PC_Write=1. FETCH never asserts PC_Write, so each instruction counts exactly once.
- Wait counter clears on every state change. It never exceeds MEM_WAIT.
- Reset asserted mid-instruction aborts it immediately. No write strobe is issued after reset falls.
- Outputs are Moore-decoded from state and counter, except the BRANCH_CMP next-state decision, which is combinational on igual.

Optional Feature:
UC_ILLEGAL_TRAP_EN
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all strobes 0 with illegal=1 and halted=1 until reset. instr_count is not incremented.
- Undefined: an unknown opcode goes to PC_INC and executes as a NOP, incrementing instr_count. illegal is tied to 0 and no TRAP state exists.

Test Plan:
1. Hold reset=0 for 3 cycles, then release -> during reset all outputs 0 and state_dbg=INIT. First cycle after release: reset_A=1. Next cycle: FETCH with register_Inst_wr=1 (MEM_WAIT=0).
2. MEM_WAIT=0, Op=0110011, Funct7_5=1 -> FETCH, DECODE, EXEC_R (Seletor=010), WB_ALU (bancoRegisters_wr=1, Mux_Banco=0, PC_Write=1). 4 cycles total; instr_count 0->1.
3. MEM_WAIT=2, Op=0000011 -> FETCH 3 cycles (load_ir only in the 3rd), DECODE, ADDR, MEM_RD 3 cycles, WB_MEM (Mux_Banco=1). 9 cycles total.
4. Op=1100011, Funct3=000: with igual=1 -> BRANCH_TAKE with A=2, B=4, PC_Write=1; repeat with igual=0 -> PC_INC with B=1. Funct3=001 with igual=1 -> PC_INC.
5. Op=1110011 -> HALT; halted=1 and no strobes for 20 cycles. Assert reset=0 mid-HALT -> INIT, halted=0. Op=0100011 with MEM_WAIT=1 -> Data_Memory_wr high exactly 2 cycles.
6. Op=1111111: without UC_ILLEGAL_TRAP_EN -> PC_INC, instr_count+1, illegal=0. With the macro -> TRAP, illegal=1, halted=1, instr_count unchanged.
